word_align_ctrl: RTL and testbench

- Bit-slip sequencer for the FE-I4 receive path.
- Watches 10-bit words from the phase aligner and finds the K28.5 comma at word offset 0.
- Issues single-cycle BITSLIP pulses until the comma is aligned, declares word lock, and re-hunts on loss of lock.
- After a full rotation with no lock, requests a phase-aligner recalibration. Sits between the phase aligner and the 8b10b decoder.

---
 rtl/word_align_ctrl_if.sv | 25 ++
 rtl/word_align_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_word_align_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_align_ctrl_if.sv
// Word-alignment bus between the phase aligner, the bit-slip sequencer and its status consumers.
// master drives the aligner side; slave is the sequencer.
interface word_align_ctrl_if #(
    parameter int unsigned DSIZE = 10
);
    logic [DSIZE-1:0] WORD;
    logic             WORD_STB;
    logic             PA_READY;
    logic             PA_ERROR;
    logic             BITSLIP;
    logic             RECAL_REQ;
    logic             ALIGNED;
    logic [3:0]       SLIP_CNT;
    logic [7:0]       RELOCK_CNT;

    modport master (
        output WORD, WORD_STB, PA_READY, PA_ERROR,
        input  BITSLIP, RECAL_REQ, ALIGNED, SLIP_CNT, RELOCK_CNT
    );

    modport slave (
        input  WORD, WORD_STB, PA_READY, PA_ERROR,
        output BITSLIP, RECAL_REQ, ALIGNED, SLIP_CNT, RELOCK_CNT
    );
endinterface

// File: rtl/word_align_ctrl.sv
// Bit-slip sequencer: hunts for the K28.5 comma at word offset 0, slips the phase aligner one
// bit at a time until it is found, holds word lock and asks for recalibration after a full rotation.
module word_align_ctrl #(
    parameter int unsigned DSIZE        = 10,
    parameter int unsigned HUNT_WORDS   = 64,
    parameter int unsigned SETTLE_WORDS = 4,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned LOSS_WORDS   = 1024
) (
    input  logic                    FCLK,
    input  logic                    RST,
    word_align_ctrl_if.slave        io_bus
);

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StSlip,
        StSettle,
        StLocked,
        StFail
    } state_e;

    localparam logic [DSIZE-1:0] K28_5_NEG  = DSIZE'(10'b0011111010);
    localparam logic [DSIZE-1:0] K28_5_POS  = DSIZE'(10'b1100000101);
    localparam logic [15:0]      HUNT_LIM   = 16'(HUNT_WORDS);
    localparam logic [15:0]      SETTLE_LIM = 16'(SETTLE_WORDS);
    localparam logic [15:0]      LOSS_LIM   = 16'(LOSS_WORDS);
    localparam logic [7:0]       LOCK_LIM   = 8'(LOCK_COUNT);
    localparam logic [3:0]       SLIP_LAST  = 4'(DSIZE - 1);

    state_e      r_state;
    logic        r_rdy_meta;
    logic        r_rdy_s;
    logic        r_err_meta;
    logic        r_err_s;
    logic [15:0] r_word_cnt;
    logic [15:0] r_miss_cnt;
    logic [7:0]  r_comma_cnt;
    logic [3:0]  r_slip_cnt;
    logic [7:0]  r_relock_cnt;
    logic        r_bitslip;
    logic        r_recal;
    logic        r_aligned;

    logic        w_stb;
    logic        w_comma;
    logic        w_go_idle;
    logic        w_hunt_ok;
    logic [15:0] w_word_inc;
    logic [15:0] w_miss_inc;
    logic [7:0]  w_comma_inc;
    logic [7:0]  w_relock_inc;

    assign w_stb   = io_bus.WORD_STB;
    assign w_comma = io_bus.WORD_STB &&
                     ((io_bus.WORD == K28_5_NEG) || (io_bus.WORD == K28_5_POS));

    // Aligner not ready or in error forces everything back to IDLE from any active state.
    assign w_go_idle = (r_state != StIdle) && (!r_rdy_s || r_err_s);
    assign w_hunt_ok = r_rdy_s && !r_err_s;

    // Counters saturate rather than wrap.
    assign w_word_inc   = (r_word_cnt == '1)   ? r_word_cnt   : r_word_cnt + 16'd1;
    assign w_miss_inc   = (r_miss_cnt == '1)   ? r_miss_cnt   : r_miss_cnt + 16'd1;
    assign w_comma_inc  = (r_comma_cnt == '1)  ? r_comma_cnt  : r_comma_cnt + 8'd1;
    assign w_relock_inc = (r_relock_cnt == '1) ? r_relock_cnt : r_relock_cnt + 8'd1;

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            r_state      <= StIdle;
            r_rdy_meta   <= 1'b0;
            r_rdy_s      <= 1'b0;
            r_err_meta   <= 1'b0;
            r_err_s      <= 1'b0;
            r_word_cnt   <= '0;
            r_miss_cnt   <= '0;
            r_comma_cnt  <= '0;
            r_slip_cnt   <= '0;
            r_relock_cnt <= '0;
            r_bitslip    <= 1'b0;
            r_recal      <= 1'b0;
            r_aligned    <= 1'b0;
        end else begin
            r_rdy_meta <= io_bus.PA_READY;
            r_rdy_s    <= r_rdy_meta;
            r_err_meta <= io_bus.PA_ERROR;
            r_err_s    <= r_err_meta;

            // Pulse outputs default low so they can only ever be one FCLK wide.
            r_bitslip <= 1'b0;
            r_recal   <= 1'b0;

            if (w_go_idle) begin
                r_state     <= StIdle;
                r_aligned   <= 1'b0;
                r_word_cnt  <= '0;
                r_comma_cnt <= '0;
                r_miss_cnt  <= '0;
                r_slip_cnt  <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_word_cnt  <= '0;
                        r_comma_cnt <= '0;
                        r_slip_cnt  <= '0;
                        if (w_hunt_ok) begin
                            r_state <= StHunt;
                        end
                    end

                    StHunt: begin
                        if (w_stb) begin
                            r_word_cnt <= w_word_inc;
                            if (w_comma) begin
                                r_comma_cnt <= w_comma_inc;
                            end
                            // Lock takes priority over a window timeout on the same strobe.
                            if (w_comma && (w_comma_inc >= LOCK_LIM)) begin
                                r_state    <= StLocked;
                                r_aligned  <= 1'b1;
                                r_miss_cnt <= '0;
                            end else if (w_word_inc >= HUNT_LIM) begin
                                r_state <= (r_slip_cnt == SLIP_LAST) ? StFail : StSlip;
                            end
                        end
                    end

                    StSlip: begin
                        r_bitslip  <= 1'b1;
                        r_slip_cnt <= r_slip_cnt + 4'd1;
                        r_word_cnt <= '0;
                        r_state    <= StSettle;
                    end

                    // word_cnt doubles as the settle counter here.
                    StSettle: begin
                        if (w_stb) begin
                            if (w_word_inc >= SETTLE_LIM) begin
                                r_state     <= StHunt;
                                r_word_cnt  <= '0;
                                r_comma_cnt <= '0;
                            end else begin
                                r_word_cnt <= w_word_inc;
                            end
                        end
                    end

                    StLocked: begin
                        if (w_stb) begin
                            if (w_comma) begin
                                r_miss_cnt <= '0;
                            end else if (w_miss_inc >= LOSS_LIM) begin
                                // Re-hunt from the current slip position.
                                r_state      <= StHunt;
                                r_aligned    <= 1'b0;
                                r_relock_cnt <= w_relock_inc;
                                r_slip_cnt   <= '0;
                                r_word_cnt   <= '0;
                                r_comma_cnt  <= '0;
                                r_miss_cnt   <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                            end
                        end
                    end

                    StFail: begin
                        r_recal     <= 1'b1;
                        r_state     <= StIdle;
                        r_word_cnt  <= '0;
                        r_comma_cnt <= '0;
                        r_slip_cnt  <= '0;
                    end

                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign io_bus.BITSLIP    = r_bitslip;
    assign io_bus.RECAL_REQ  = r_recal;
    assign io_bus.ALIGNED    = r_aligned;
    assign io_bus.SLIP_CNT   = r_slip_cnt;
    assign io_bus.RELOCK_CNT = r_relock_cnt;

endmodule

// File: tb/tb_word_align_ctrl.sv
// Scoreboard bench for word_align_ctrl: a rotating phase-aligner model feeds words, expected
// slip/lock/recal events are queued per scenario and matched as the DUT emits them.
module tb_word_align_ctrl;

    localparam int         DSIZE  = 10;
    localparam logic [9:0] COMMA  = 10'b0011111010;
    localparam logic [9:0] FILLER = 10'b0101010101;

    typedef enum int {EvSlip, EvRecal, EvLock, EvUnlock} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       slip;
        int       relock;
    } ev_t;

    logic FCLK = 1'b0;
    logic RST  = 1'b1;
    always #5 FCLK = ~FCLK;

    word_align_ctrl_if #(.DSIZE(DSIZE)) bus ();

    word_align_ctrl #(
        .DSIZE       (DSIZE),
        .HUNT_WORDS  (64),
        .SETTLE_WORDS(4),
        .LOCK_COUNT  (4),
        .LOSS_WORDS  (1024)
    ) dut (
        .FCLK  (FCLK),
        .RST   (RST),
        .io_bus(bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    ev_t        sb_q[$];
    logic       gen_en = 1'b0;
    logic [9:0] tx_word = COMMA;
    int         offset = 0;
    int         gen_phase = 0;
    int         stb_count = 0;
    int         n_slips = 0;
    int         lock_stb = -1;
    int         unlock_stb = -1;
    int         recal_stb = -1;
    int         last_mark = 0;
    logic       have_mark = 1'b0;
    logic       gen_bs_prev = 1'b0;
    logic       p_bs = 1'b0;
    logic       p_rc = 1'b0;
    logic       p_al = 1'b0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
        logic [19:0] d;
        d = {w, w} << k;
        return d[19:10];
    endfunction

    function automatic void sb_push(input ev_kind_e k, input int s, input int r);
        ev_t e;
        e.kind   = k;
        e.slip   = s;
        e.relock = r;
        sb_q.push_back(e);
    endfunction

    task automatic sb_pop(input ev_kind_e k);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_val("unexpected_event", int'(k), -1);
        end else begin
            e = sb_q.pop_front();
            check_val("ev_kind", int'(k), int'(e.kind));
            check_val("ev_slip_cnt", int'(bus.SLIP_CNT), e.slip);
            check_val("ev_relock_cnt", int'(bus.RELOCK_CNT), e.relock);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge FCLK);
            #3;
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < max_cyc) begin
            @(posedge FCLK);
            #3;
            i++;
        end
        check_val("sb_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_aligned(input logic v, input int max_cyc);
        int i;
        i = 0;
        while (bus.ALIGNED !== v && i < max_cyc) begin
            @(posedge FCLK);
            #3;
            i++;
        end
        check_val("aligned_wait", int'(bus.ALIGNED), int'(v));
    endtask

    task automatic start_stream();
        stb_count = 0;
        gen_phase = 0;
        n_slips   = 0;
        have_mark = 1'b0;
        gen_en    = 1'b1;
    endtask

    // Phase-aligner model: one word every 10 FCLK, rotated back one bit per BITSLIP edge.
    initial begin
        bus.WORD     = '0;
        bus.WORD_STB = 1'b0;
        forever begin
            @(posedge FCLK);
            #1;
            if (bus.BITSLIP && !gen_bs_prev) offset = (offset + DSIZE - 1) % DSIZE;
            gen_bs_prev = bus.BITSLIP;
            if (gen_en && gen_phase >= 9) begin
                gen_phase    = 0;
                bus.WORD     = rotl(tx_word, offset);
                bus.WORD_STB = 1'b1;
                stb_count++;
            end else begin
                bus.WORD_STB = 1'b0;
                if (gen_en) gen_phase++;
            end
        end
    end

    // Event monitor, sampled on the falling edge.
    initial begin
        int mark;
        forever begin
            @(negedge FCLK);
            if (p_bs) check_val("bitslip_width", int'(bus.BITSLIP), 0);
            if (p_rc) check_val("recal_width", int'(bus.RECAL_REQ), 0);
            if (bus.BITSLIP && !p_bs) begin
                n_slips++;
                mark = stb_count - int'(bus.WORD_STB);
                if (have_mark) check_val("slip_gap_ge68", int'((mark - last_mark) >= 68), 1);
                last_mark = mark;
                have_mark = 1'b1;
                sb_pop(EvSlip);
            end
            if (bus.RECAL_REQ && !p_rc) begin
                recal_stb = stb_count;
                sb_pop(EvRecal);
            end
            if (bus.ALIGNED && !p_al) begin
                lock_stb = stb_count;
                sb_pop(EvLock);
            end
            if (!bus.ALIGNED && p_al) begin
                unlock_stb = stb_count;
                sb_pop(EvUnlock);
            end
            p_bs = bus.BITSLIP;
            p_rc = bus.RECAL_REQ;
            p_al = bus.ALIGNED;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.PA_READY = 1'b0;
        bus.PA_ERROR = 1'b0;
        RST = 1'b1;
        wait_cycles(3);
        check_val("rst_bitslip", int'(bus.BITSLIP), 0);
        check_val("rst_recal", int'(bus.RECAL_REQ), 0);
        check_val("rst_aligned", int'(bus.ALIGNED), 0);
        check_val("rst_slip_cnt", int'(bus.SLIP_CNT), 0);
        check_val("rst_relock_cnt", int'(bus.RELOCK_CNT), 0);
        RST = 1'b0;

        // Aligned comma stream locks after exactly 4 strobes without slipping.
        tx_word = COMMA;
        offset = 0;
        bus.PA_READY = 1'b1;
        wait_cycles(6);
        start_stream();
        sb_push(EvLock, 0, 0);
        wait_drain(300);
        check_val("t1_lock_strobes", lock_stb, 4);
        check_val("t1_slips", n_slips, 0);

        // Loss of commas for 1024 words drops lock; restored commas relock in place.
        sb_push(EvUnlock, 0, 1);
        sb_push(EvLock, 0, 1);
        tx_word = FILLER;
        stb_count = 0;
        wait_aligned(1'b0, 11000);
        tx_word = COMMA;
        wait_cycles(1);
        check_val("t4_unlock_strobes", unlock_stb, 1024);
        wait_drain(300);
        check_val("t4_slips", n_slips, 0);

        // Stream rotated by 3 bits: three slips then lock; READY drop must not bump RELOCK_CNT.
        sb_push(EvUnlock, 0, 1);
        gen_en = 1'b0;
        bus.PA_READY = 1'b0;
        wait_cycles(6);
        wait_drain(10);
        tx_word = COMMA;
        offset = 3;
        bus.PA_READY = 1'b1;
        wait_cycles(6);
        start_stream();
        for (int k = 1; k <= 3; k++) sb_push(EvSlip, k, 1);
        sb_push(EvLock, 3, 1);
        wait_drain(4000);
        check_val("t2_slips", n_slips, 3);

        // No comma ever: 9 slips, recalibration request, then a fresh hunt.
        sb_push(EvUnlock, 0, 1);
        gen_en = 1'b0;
        bus.PA_READY = 1'b0;
        wait_cycles(6);
        wait_drain(10);
        tx_word = FILLER;
        offset = 0;
        bus.PA_READY = 1'b1;
        wait_cycles(6);
        start_stream();
        for (int k = 1; k <= 9; k++) sb_push(EvSlip, k, 1);
        sb_push(EvRecal, 0, 1);
        sb_push(EvSlip, 1, 1);
        wait_drain(8500);
        check_val("t3_recal_strobes", recal_stb, 676);
        check_val("t3_slips", n_slips, 10);

        // READY drops while settling after that slip: back to IDLE within 3 cycles, no slips.
        bus.PA_READY = 1'b0;
        wait_cycles(3);
        check_val("t5_slip_cnt_cleared", int'(bus.SLIP_CNT), 0);
        check_val("t5_bitslip_low", int'(bus.BITSLIP), 0);
        n_slips = 0;
        wait_cycles(800);
        check_val("t5_no_slips", n_slips, 0);
        check_val("t5_not_aligned", int'(bus.ALIGNED), 0);
        bus.PA_READY = 1'b1;

        // Reset lands in the cycle BITSLIP is high.
        begin
            int i;
            i = 0;
            while (bus.BITSLIP !== 1'b1 && i < 1500) begin
                @(posedge FCLK);
                #3;
                i++;
            end
        end
        check_val("t6_bitslip_seen", int'(bus.BITSLIP), 1);
        RST = 1'b1;
        #1;
        check_val("t6_bitslip_cleared", int'(bus.BITSLIP), 0);
        check_val("t6_slip_cnt", int'(bus.SLIP_CNT), 0);
        check_val("t6_relock_cnt", int'(bus.RELOCK_CNT), 0);
        check_val("t6_aligned", int'(bus.ALIGNED), 0);
        check_val("t6_recal", int'(bus.RECAL_REQ), 0);
        bus.PA_ERROR = 1'b1;
        tx_word = COMMA;
        offset = 0;
        wait_cycles(2);
        RST = 1'b0;
        n_slips = 0;
        wait_cycles(800);
        check_val("t6_err_hold_aligned", int'(bus.ALIGNED), 0);
        check_val("t6_err_hold_slips", n_slips, 0);
        check_val("t6_err_hold_slip_cnt", int'(bus.SLIP_CNT), 0);
        sb_push(EvLock, 0, 0);
        bus.PA_ERROR = 1'b0;
        wait_drain(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
